fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter IMEM_DEPTH, default 1024, instruction memory size in bytes.
REQ-002 Parameter ADDR_W, default 64, PC and memory address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 imem_we  in  1  instruction-memory byte write enable.
REQ-006 imem_waddr  in  ADDR_W  byte write address.
REQ-007 imem_wdata  in  8  byte write data.
REQ-008 F_stall  in  1  hold the predicted-PC register.
REQ-009 D_stall  in  1  hold the D pipeline register.
REQ-010 D_bubble  in  1  load a NOP bubble into the D register.
REQ-011 M_icode  in  4  icode in memory stage.
REQ-012 M_cnd  in  1  branch condition in memory stage.
REQ-013 M_valA  in  64  fall-through PC of the memory-stage jump.
REQ-014 W_icode  in  4  icode in write-back stage.
REQ-015 W_valM  in  64  return address in write-back stage.
REQ-016 f_pc  out  ADDR_W  selected fetch PC, combinational.
REQ-017 D_stat  out  3  registered status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-018 D_icode, D_ifun, D_rA, D_rB  out  4 each  registered instruction fields.
REQ-019 D_valC, D_valP  out  64 each  registered constant and next-sequential PC.

Function
REQ-020 f_pc SHALL be M_valA if M_icode==JXX(7) and !M_cnd; else W_valM if W_icode==RET(9); else F_predPC.
REQ-021 Memory read SHALL be combinational over 10 bytes from f_pc; a write SHALL take effect on the next rising edge, so a same-cycle read returns the old byte.
REQ-022 icode/ifun SHALL come from byte 0, high/low nibble; rA/rB from byte 1, high/low nibble.
REQ-023 need_regids SHALL be 1 for icodes 2,3,4,5,6,A,B; need_valC for icodes 3,4,5,7,8.
REQ-024 valC SHALL be 8 bytes little-endian, starting at byte 2 if need_regids, else byte 1; otherwise 0.
REQ-025 rA/rB SHALL be 4'hF when need_regids is 0.
REQ-026 valP SHALL be f_pc + 1 + need_regids + 8*need_valC, truncated to 64 bits.
REQ-027 instr_valid SHALL be set for icode 0..B:
- icode 2 or 7: ifun<=6.
- icode 6: ifun<=3.
- all other icodes: ifun==0.
REQ-028 imem_error SHALL be set when f_pc + instruction length - 1 >= IMEM_DEPTH, including address wrap-around; out-of-range bytes SHALL read as 0.
REQ-029 Status priority SHALL be imem_error -> ADR (icode/ifun forced to 1/0), else !instr_valid -> INS, else icode 0 -> HLT, else AOK.
REQ-030 predPC SHALL be valC for icodes 7 and 8, else valP.
REQ-031 F_predPC SHALL load predPC each edge unless F_stall.
REQ-032 D register update SHALL be: D_bubble -> bubble (stat AOK, icode 1, ifun 0, rA=rB=F, valC=valP=0); else D_stall -> hold; else load fetched fields. D_bubble SHALL win over a simultaneous D_stall.
REQ-033 Fetch SHALL continue after HLT; pipeline control is responsible for stopping.

Reset
REQ-034 rst SHALL asynchronously set F_predPC=0 and load the D register with the bubble value of REQ-032.
REQ-035 rst SHALL NOT clear memory contents; releasing rst in the middle of a program restarts fetch at PC 0.

Structure
REQ-036 Package y86_pkg SHALL hold icode constants, stat codes, REG_NONE=4'hF, and the bubble value.
REQ-037 A combinational sub-module instr_align SHALL perform split/align/valid/length; fetch_stage holds the memory, PC select, and registers.

Verification
REQ-038 Load 30 F3 13 00 00 00 00 00 00 00 at addr 0, release rst -> after 1 edge D_icode=3, D_rB=3, D_valC=0x13, D_valP=10, D_stat=AOK.
REQ-039 Byte 0x70 with valC 0x40; next cycle M_icode=7, M_cnd=0, M_valA=9 -> predPC=0x40, then f_pc=9.
REQ-040 W_icode=9, W_valM=0x80 with M_icode=7, M_cnd=0, M_valA=0x20 -> f_pc=0x20 (misprediction wins).
REQ-041 Byte 0x27 at f_pc=0 -> D_stat=INS; byte 0x00 -> D_stat=HLT, valP=1.
REQ-042 10-byte instruction at f_pc=IMEM_DEPTH-5 -> D_stat=ADR, D_icode=1.
REQ-043 D_stall and D_bubble together -> D holds the bubble; F_stall=1 for 3 edges -> f_pc unchanged; rst pulsed mid-run -> f_pc=0 and D holds the bubble immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status codes, the
// D-register layout with its bubble value, and instruction-class helpers.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  // Longest Y86 instruction: icode/ifun, register byte, 8-byte constant.
  localparam int MAX_ILEN = 10;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  typedef struct packed {
    stat_t       stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    ra:    REG_NONE,
    rb:    REG_NONE,
    valc:  64'd0,
    valp:  64'd0
  };

  function automatic logic needs_regids(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ: needs_regids = 1'b1;
      default:                needs_regids = 1'b0;
    endcase
  endfunction

  function automatic logic needs_valc(input logic [3:0] icode);
    case (icode)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: needs_valc = 1'b1;
      default:                                     needs_valc = 1'b0;
    endcase
  endfunction

  // Jumps and conditional moves share seven condition codes; OPq has four ALU ops.
  function automatic logic is_valid_instr(input logic [3:0] icode, input logic [3:0] ifun);
    case (icode)
      I_RRMOVQ, I_JXX: is_valid_instr = (ifun <= 4'd6);
      I_OPQ:           is_valid_instr = (ifun <= 4'd3);
      I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_CALL, I_RET, I_PUSHQ, I_POPQ:
                       is_valid_instr = (ifun == 4'h0);
      default:         is_valid_instr = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_stage_instr_align.sv
// Combinational decode of a 10-byte fetch window into instruction fields,
// validity and instruction length.
module instr_align
  import y86_pkg::*;
(
  input  logic [MAX_ILEN-1:0][7:0] ibytes,
  output logic [3:0]               icode,
  output logic [3:0]               ifun,
  output logic [3:0]               ra,
  output logic [3:0]               rb,
  output logic [63:0]              valc,
  output logic                     instr_valid,
  output logic [3:0]               ilen
);

  logic need_regids;
  logic need_valc;

  always_comb begin
    icode       = ibytes[0][7:4];
    ifun        = ibytes[0][3:0];
    need_regids = needs_regids(icode);
    need_valc   = needs_valc(icode);
    instr_valid = is_valid_instr(icode, ifun);

    ra = REG_NONE;
    rb = REG_NONE;
    if (need_regids) begin
      ra = ibytes[1][7:4];
      rb = ibytes[1][3:0];
    end

    // Packed byte order makes the higher-addressed byte the MSB: little-endian.
    valc = 64'd0;
    if (need_valc) begin
      if (need_regids) valc = ibytes[9:2];
      else             valc = ibytes[8:1];
    end

    ilen = 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: byte-wide instruction memory, PC selection,
// predicted-PC register and the F/D pipeline register.
module fetch_stage
  import y86_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [7:0]        imem_wdata,
  input  logic              F_stall,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic [3:0]        M_icode,
  input  logic              M_cnd,
  input  logic [63:0]       M_valA,
  input  logic [3:0]        W_icode,
  input  logic [63:0]       W_valM,
  output logic [ADDR_W-1:0] f_pc,
  output logic [2:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [63:0]       D_valC,
  output logic [63:0]       D_valP
);

  localparam int IDX_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  // One extra bit so address + offset never wraps before the range check.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(IMEM_DEPTH);

  logic [7:0] imem [IMEM_DEPTH];

  logic [ADDR_W-1:0] pred_pc_reg;
  logic [ADDR_W-1:0] pred_pc_next;
  d_reg_t            d_reg;
  d_reg_t            d_next;

  logic [MAX_ILEN-1:0][7:0] fetch_bytes;
  logic [3:0]               icode;
  logic [3:0]               ifun;
  logic [3:0]               ra;
  logic [3:0]               rb;
  logic [63:0]              valc;
  logic                     instr_valid;
  logic [3:0]               ilen;
  logic [ADDR_W:0]          last_addr;
  logic                     imem_error;
  logic [ADDR_W-1:0]        valp;
  logic [ADDR_W-1:0]        f_pred_pc;
  d_reg_t                   f_d;

  // Memory contents survive reset so a program can be preloaded under rst.
  always_ff @(posedge clk) begin
    if (imem_we && ({1'b0, imem_waddr} < DEPTH_EXT)) begin
      imem[imem_waddr[IDX_W-1:0]] <= imem_wdata;
    end
  end

  // A mispredicted jump must redirect before a return can.
  always_comb begin
    f_pc = pred_pc_reg;
    if (M_icode == I_JXX && !M_cnd) begin
      f_pc = ADDR_W'(M_valA);
    end else if (W_icode == I_RET) begin
      f_pc = ADDR_W'(W_valM);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_ILEN; gi++) begin : g_fetch_byte
      logic [ADDR_W:0] byte_addr;
      assign byte_addr       = {1'b0, f_pc} + (ADDR_W + 1)'(gi);
      assign fetch_bytes[gi] = (byte_addr < DEPTH_EXT) ? imem[byte_addr[IDX_W-1:0]] : 8'h00;
    end
  endgenerate

  instr_align u_align (
    .ibytes      (fetch_bytes),
    .icode       (icode),
    .ifun        (ifun),
    .ra          (ra),
    .rb          (rb),
    .valc        (valc),
    .instr_valid (instr_valid),
    .ilen        (ilen)
  );

  always_comb begin
    last_addr  = {1'b0, f_pc} + (ADDR_W + 1)'(ilen) - (ADDR_W + 1)'(1);
    imem_error = (last_addr >= DEPTH_EXT);
    valp       = f_pc + ADDR_W'(ilen);

    f_d       = D_BUBBLE;
    f_d.icode = icode;
    f_d.ifun  = ifun;
    f_d.ra    = ra;
    f_d.rb    = rb;
    f_d.valc  = valc;
    f_d.valp  = 64'(valp);

    if (imem_error) begin
      f_d.stat  = STAT_ADR;
      f_d.icode = I_NOP;
      f_d.ifun  = 4'h0;
    end else if (!instr_valid) begin
      f_d.stat = STAT_INS;
    end else if (icode == I_HALT) begin
      f_d.stat = STAT_HLT;
    end else begin
      f_d.stat = STAT_AOK;
    end

    f_pred_pc = (icode == I_JXX || icode == I_CALL) ? ADDR_W'(valc) : valp;
  end

  always_comb begin
    pred_pc_next = F_stall ? pred_pc_reg : f_pred_pc;

    d_next = f_d;
    if (D_bubble) begin
      d_next = D_BUBBLE;
    end else if (D_stall) begin
      d_next = d_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_pc_reg <= '0;
      d_reg       <= D_BUBBLE;
    end else begin
      pred_pc_reg <= pred_pc_next;
      d_reg       <= d_next;
    end
  end

  assign D_stat  = d_reg.stat;
  assign D_icode = d_reg.icode;
  assign D_ifun  = d_reg.ifun;
  assign D_rA    = d_reg.ra;
  assign D_rB    = d_reg.rb;
  assign D_valC  = d_reg.valc;
  assign D_valP  = d_reg.valp;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_fetch_stage;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_we = 1'b0;
  logic [63:0] imem_waddr = '0;
  logic [7:0]  imem_wdata = '0;
  logic        F_stall = 1'b0;
  logic        D_stall = 1'b0;
  logic        D_bubble = 1'b0;
  logic [3:0]  M_icode = '0;
  logic        M_cnd = 1'b0;
  logic [63:0] M_valA = '0;
  logic [3:0]  W_icode = '0;
  logic [63:0] W_valM = '0;
  logic [63:0] f_pc;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;

  fetch_stage #(.IMEM_DEPTH(DEPTH), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .f_pc(f_pc), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
  } dexp_t;

  localparam dexp_t BUB = '{stat: 3'd1, icode: 4'd1, ifun: 4'd0, ra: 4'hF, rb: 4'hF,
                            valc: 64'd0, valp: 64'd0};

  logic [7:0]  mem_m [DEPTH];
  logic [63:0] pred_m;
  dexp_t       d_m;

  function automatic logic [63:0] exp_fpc();
    if (M_icode == 4'd7 && !M_cnd) return M_valA;
    if (W_icode == 4'd9) return W_valM;
    return pred_m;
  endfunction

  function automatic void model_fetch(input logic [63:0] pc, output dexp_t d, output logic [63:0] np);
    logic [7:0] b [10];
    logic [3:0] ic, fn;
    bit regs, cval, valid, err;
    int len, start;
    for (int k = 0; k < 10; k++) begin
      b[k] = 8'h00;
      if (pc < 64'(DEPTH)) begin
        if (64'(k) < 64'(DEPTH) - pc) b[k] = mem_m[int'(pc) + k];
      end
    end
    ic    = b[0][7:4];
    fn    = b[0][3:0];
    regs  = ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    cval  = ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    len   = 1 + int'(regs) + 8 * int'(cval);
    start = regs ? 2 : 1;
    if (ic == 4'h2 || ic == 4'h7)  valid = (fn <= 4'd6);
    else if (ic == 4'h6)           valid = (fn <= 4'd3);
    else if (ic <= 4'hB)           valid = (fn == 4'd0);
    else                           valid = 1'b0;
    err = (pc >= 64'(DEPTH)) || (64'(DEPTH) - pc < 64'(len));
    d.icode = ic;
    d.ifun  = fn;
    d.ra    = regs ? b[1][7:4] : 4'hF;
    d.rb    = regs ? b[1][3:0] : 4'hF;
    d.valc  = 64'd0;
    if (cval) for (int j = 0; j < 8; j++) d.valc = d.valc | (64'(b[start + j]) << (8 * j));
    d.valp  = pc + 64'(len);
    if (err)          begin d.stat = 3'd3; d.icode = 4'd1; d.ifun = 4'd0; end
    else if (!valid)  d.stat = 3'd4;
    else if (ic == 0) d.stat = 3'd2;
    else              d.stat = 3'd1;
    np = (ic == 4'h7 || ic == 4'h8) ? d.valc : d.valp;
  endfunction

  always @(posedge clk or posedge rst) begin
    dexp_t       fd;
    logic [63:0] np;
    if (rst) begin
      pred_m <= 64'd0;
      d_m    <= BUB;
    end else begin
      model_fetch(exp_fpc(), fd, np);
      if (!F_stall) pred_m <= np;
      if (D_bubble)     d_m <= BUB;
      else if (!D_stall) d_m <= fd;
    end
  end

  always @(posedge clk) begin
    if (imem_we && imem_waddr < 64'(DEPTH)) mem_m[imem_waddr[9:0]] <= imem_wdata;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("f_pc",    f_pc,    exp_fpc());
      chk("D_stat",  64'(D_stat),  64'(d_m.stat));
      chk("D_icode", 64'(D_icode), 64'(d_m.icode));
      chk("D_ifun",  64'(D_ifun),  64'(d_m.ifun));
      chk("D_rArB",  64'({D_rA, D_rB}), 64'({d_m.ra, d_m.rb}));
      chk("D_valC",  D_valC, d_m.valc);
      chk("D_valP",  D_valP, d_m.valp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] v);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = v;
    tick();
    imem_we = 1'b0;
  endtask

  // Writes three leading bytes then seven zero bytes starting at base.
  task automatic load(input logic [63:0] base, input logic [7:0] b0, b1, b2);
    wr(base, b0); wr(base + 1, b1); wr(base + 2, b2);
    for (int k = 3; k < 10; k++) wr(base + 64'(k), 8'h00);
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(); tick();
    for (int a = 0; a < DEPTH; a++) begin
      imem_we = 1'b1; imem_waddr = 64'(a); imem_wdata = 8'h00;
      tick();
    end
    imem_we = 1'b0;
    chk_en = 1'b1;
    chk("rst_fpc", f_pc, 64'd0);
    chk("rst_icode", 64'(D_icode), 64'd1);
    chk("rst_rA", 64'(D_rA), 64'hF);

    // irmovq $0x13, %rbx
    load(0, 8'h30, 8'hF3, 8'h13);
    rst = 1'b0;
    tick();
    $display("txn irmovq: D_icode=%h D_rB=%h D_valC=%h D_valP=%h D_stat=%0d", D_icode, D_rB, D_valC, D_valP, D_stat);
    chk("irm_icode", 64'(D_icode), 64'd3);
    chk("irm_rB", 64'(D_rB), 64'd3);
    chk("irm_valC", D_valC, 64'h13);
    chk("irm_valP", D_valP, 64'd10);
    chk("irm_stat", 64'(D_stat), 64'd1);
    chk("irm_fpc", f_pc, 64'd10);
    tick();
    chk("hlt_after_stat", 64'(D_stat), 64'd2);
    chk("hlt_after_valP", D_valP, 64'd11);

    // jmp 0x40 predicted taken, then mispredicted in M
    rst = 1'b1;
    load(0, 8'h70, 8'h40, 8'h00);
    rst = 1'b0;
    tick();
    $display("txn jxx: f_pc=%h D_valC=%h D_valP=%h", f_pc, D_valC, D_valP);
    chk("jxx_pred", f_pc, 64'h40);
    chk("jxx_valP", D_valP, 64'd9);
    M_icode = 4'd7; M_cnd = 1'b0; M_valA = 64'd9;
    #1 chk("jxx_mispredict", f_pc, 64'd9);
    tick();
    W_icode = 4'd9; W_valM = 64'h80; M_valA = 64'h20;
    #1 chk("mispredict_over_ret", f_pc, 64'h20);
    M_cnd = 1'b1;
    #1 chk("ret_select", f_pc, 64'h80);
    $display("txn ret: f_pc=%h", f_pc);
    tick();
    M_icode = 4'd0; M_cnd = 1'b0; W_icode = 4'd0;

    // status encodings
    rst = 1'b1; load(0, 8'h27, 8'h00, 8'h00); rst = 1'b0; tick();
    chk("ins_27", 64'(D_stat), 64'd4);
    rst = 1'b1; load(0, 8'h64, 8'h12, 8'h00); rst = 1'b0; tick();
    chk("ins_64", 64'(D_stat), 64'd4);
    rst = 1'b1; load(0, 8'h26, 8'h12, 8'h00); rst = 1'b0; tick();
    chk("rr_ok_stat", 64'(D_stat), 64'd1);
    chk("rr_ok_valP", D_valP, 64'd2);
    rst = 1'b1; load(0, 8'h00, 8'h00, 8'h00); rst = 1'b0; tick();
    chk("hlt_stat", 64'(D_stat), 64'd2);
    chk("hlt_valP", D_valP, 64'd1);
    $display("txn status: D_stat=%0d D_valP=%h", D_stat, D_valP);

    // memory-end boundary: instruction crossing the end vs. ending exactly at it
    rst = 1'b1;
    load(64'(DEPTH - 10), 8'h30, 8'hF1, 8'h05);
    load(64'(DEPTH - 5), 8'h30, 8'hF1, 8'h05);
    rst = 1'b0;
    M_icode = 4'd7; M_valA = 64'(DEPTH - 5);
    tick();
    chk("adr_stat", 64'(D_stat), 64'd3);
    chk("adr_icode", 64'(D_icode), 64'd1);
    M_valA = 64'(DEPTH - 10);
    tick();
    chk("edge_stat", 64'(D_stat), 64'd1);
    chk("edge_valC", D_valC, 64'h0000_05F1_3000_0005);
    chk("edge_valP", D_valP, 64'(DEPTH));
    M_valA = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    chk("wrap_stat", 64'(D_stat), 64'd3);
    $display("txn boundary: D_stat=%0d D_icode=%h", D_stat, D_icode);
    M_icode = 4'd0;

    // stall / bubble control
    D_stall = 1'b1; D_bubble = 1'b1;
    tick();
    chk("bubble_wins_icode", 64'(D_icode), 64'd1);
    chk("bubble_wins_rA", 64'(D_rA), 64'hF);
    D_bubble = 1'b0;
    tick();
    chk("stall_hold_icode", 64'(D_icode), 64'd1);
    D_stall = 1'b0;

    rst = 1'b1; load(0, 8'h10, 8'h10, 8'h10); rst = 1'b0;
    F_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fstall_pc", f_pc, 64'd0);
    end
    F_stall = 1'b0;
    tick();
    chk("fstall_release", f_pc, 64'd1);
    tick(); tick();
    $display("txn stall: f_pc=%h D_icode=%h", f_pc, D_icode);

    // asynchronous reset mid-run
    rst = 1'b1;
    #1;
    chk("arst_fpc", f_pc, 64'd0);
    chk("arst_icode", 64'(D_icode), 64'd1);
    chk("arst_valP", D_valP, 64'd0);
    rst = 1'b0;
    tick();
    chk("arst_restart", f_pc, 64'd1);
    $display("txn async reset: f_pc=%h", f_pc);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
